// File: rtl/gf2m_pkg.sv
// Shared state encoding, default field constants and digit-count helper
// for the digit-serial GF(2^m) multiplier family.
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    OUT  = 2'd3
  } kmul_state_e;

  localparam int         M_AES    = 8;
  localparam logic [8:0] POLY_AES = 9'h11B;

  function automatic int num_digits(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2_kmul_digit.sv
// Combinational carry-less M x D product (width M+D-1) built as a recursive
// Karatsuba tree over the digit width, with schoolbook leaves at 2 bits.
module gf2_kmul_digit #(
  parameter int M = 8,
  parameter int D = 4
) (
  input  logic [M-1:0]   a,
  input  logic [D-1:0]   b,
  output logic [M+D-2:0] p
);

  localparam int PW = M + D - 1;

  if (D <= 2) begin : g_leaf
    always_comb begin
      p = '0;
      for (int j = 0; j < D; j++) begin
        if (b[j]) p = p ^ (PW'(a) << j);
      end
    end
  end else begin : g_split
    // Split at floor(D/2) so every partial product lands inside PW bits
    // and the recursion keeps its first operand at least as wide as the digit.
    localparam int H  = D / 2;
    localparam int AH = M - H;
    localparam int BH = D - H;
    localparam int QW = AH + BH - 1;

    logic [2*H-2:0] p0;
    logic [QW-1:0]  p2;
    logic [QW-1:0]  pm;
    logic [QW-1:0]  mid;
    logic [AH-1:0]  a_sum;
    logic [BH-1:0]  b_sum;

    assign a_sum = a[M-1:H] ^ AH'(a[H-1:0]);
    assign b_sum = b[D-1:H] ^ BH'(b[H-1:0]);

    gf2_kmul_digit #(.M(H), .D(H)) u_lo (
      .a (a[H-1:0]),
      .b (b[H-1:0]),
      .p (p0)
    );

    gf2_kmul_digit #(.M(AH), .D(BH)) u_hi (
      .a (a[M-1:H]),
      .b (b[D-1:H]),
      .p (p2)
    );

    gf2_kmul_digit #(.M(AH), .D(BH)) u_mid (
      .a (a_sum),
      .b (b_sum),
      .p (pm)
    );

    assign mid = pm ^ p2 ^ QW'(p0);
    assign p   = {p2, {(2*H){1'b0}}} ^ (PW'(mid) << H) ^ PW'(p0);
  end

endmodule

// File: rtl/gf2m_kmul_seq.sv
// Digit-serial GF(2^M) multiplier c = a*b mod POLY, one D-bit digit of b per cycle.
// Optional GF2M_KMUL_OUT_REG_EN adds a registered output stage (state OUT).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | consuming one digit of b per cycle, MSB digit first
// OUT   | loading the output register from acc (GF2M_KMUL_OUT_REG_EN only)
// DONE  | raising out_valid, holding c until out_ready
module gf2m_kmul_seq
  import gf2m_pkg::*;
#(
  parameter int         M    = M_AES,
  parameter int         D    = 4,
  parameter logic [M:0] POLY = (M+1)'(POLY_AES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c
);

  localparam int N  = num_digits(M, D);
  localparam int NW = N * D;
  localparam int FW = M + D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  kmul_state_e     state;
  logic [M-1:0]    a_reg;
  logic [NW-1:0]   b_reg;
  logic [M-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic [D-1:0]    dig;
  logic [M+D-2:0]  kprod;
  logic [FW-1:0]   fold;
  logic [M-1:0]    acc_next;

  assign dig = b_reg[NW-1 -: D];

  gf2_kmul_digit #(.M(M), .D(D)) u_kmul (
    .a (a_reg),
    .b (dig),
    .p (kprod)
  );

  // acc*x^D needs M+D bits; fold the top D bits back down, highest first.
  always_comb begin
    fold = {acc, {D{1'b0}}} ^ FW'(kprod);
    for (int i = FW - 1; i >= M; i--) begin
      if (fold[i]) fold = fold ^ (FW'(POLY) << (i - M));
    end
    acc_next = fold[M-1:0];
  end

`ifdef GF2M_KMUL_OUT_REG_EN
  logic [M-1:0] c_reg;
  assign c = c_reg;
`else
  assign c = acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
`ifdef GF2M_KMUL_OUT_REG_EN
      c_reg     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= NW'(b);
            acc      <= '0;
            cnt      <= CW'(N - 1);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          b_reg <= b_reg << D;
          if (cnt == '0) begin
`ifdef GF2M_KMUL_OUT_REG_EN
            state <= OUT;
`else
            state <= DONE;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef GF2M_KMUL_OUT_REG_EN
        OUT: begin
          c_reg <= acc;
          state <= DONE;
        end
`endif
        DONE: begin
          // out_valid rises one cycle after entering DONE; out_ready only
          // counts once the result is actually being presented.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_kmul_seq.sv
// Self-checking bench for gf2m_kmul_seq: AES-field default build plus an
// M=7/D=3 instance, both checked against a shift-and-add field model.
module tb_gf2m_kmul_seq;

  localparam int D8   = 4;
  localparam int N8   = (8 + D8 - 1) / D8;
  localparam int D7   = 3;
  localparam int N7   = (7 + D7 - 1) / D7;
`ifdef GF2M_KMUL_OUT_REG_EN
  localparam int XLAT = 2;
`else
  localparam int XLAT = 1;
`endif
  localparam int LAT8 = N8 + XLAT;
  localparam int LAT7 = N7 + XLAT;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, c;

  logic       in_valid7, in_ready7, out_valid7, out_ready7;
  logic [6:0] a7, b7, c7;

  int n_checks;
  int n_errors;

  gf2m_kmul_seq #(.M(8), .D(D8), .POLY(9'h11B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  gf2m_kmul_seq #(.M(7), .D(D7), .POLY(8'h83)) dut7 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid7),
    .in_ready  (in_ready7),
    .a         (a7),
    .b         (b7),
    .out_valid (out_valid7),
    .out_ready (out_ready7),
    .c         (c7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain polynomial-basis multiply: walk the bits of y, doubling x mod poly.
  function automatic logic [31:0] gf_mul(input logic [31:0] x, input logic [31:0] y,
                                         input int m, input logic [31:0] poly);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = x;
    for (int i = 0; i < m; i++) begin
      if (y[i]) r = r ^ s;
      s = s << 1;
      if (s[m]) s = s ^ poly;
    end
    return r;
  endfunction

  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic [31:0] expv,
                        input int hold, input logic early_rdy);
    int lat;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(in_ready), 1);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = early_rdy;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'hA5;
    b        = 8'h3C;
    check_eq("run_in_ready", 32'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(LAT8));
    check_eq("product", 32'(c), expv);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 8'($urandom);
      b         = 8'($urandom);
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 1);
      check_eq("hold_c", 32'(c), expv);
      check_eq("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("release_valid", 32'(out_valid), 0);
    check_eq("release_in_ready", 32'(in_ready), 1);
  endtask

  task automatic do_op7(input logic [6:0] av, input logic [6:0] bv);
    int          lat;
    logic [31:0] expv;
    expv = gf_mul(32'(av), 32'(bv), 7, 32'h83);
    @(negedge clk);
    a7         = av;
    b7         = bv;
    in_valid7  = 1'b1;
    out_ready7 = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid7 = 1'b0;
    lat = 0;
    while (!out_valid7 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency7", 32'(lat), 32'(LAT7));
    check_eq("product7", 32'(c7), expv);
    out_ready7 = 1'b1;
    @(negedge clk);
    out_ready7 = 1'b0;
    check_eq("release7", 32'(out_valid7), 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    in_valid7  = 1'b0;
    out_ready7 = 1'b0;
    a7         = '0;
    b7         = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_c", 32'(c), 0);
    check_eq("rst_c7", 32'(c7), 0);
    rst = 1'b0;

    do_op8(8'h57, 8'h83, 32'hC1, 0, 1'b0);
    do_op8(8'h53, 8'hCA, 32'h01, 0, 1'b1);
    do_op8(8'h57, 8'h13, 32'hFE, 0, 1'b0);
    do_op8(8'h00, 8'hFF, 32'h00, 0, 1'b0);
    do_op8(8'hA7, 8'h01, 32'hA7, 0, 1'b1);
    do_op8(8'hFF, 8'h00, 32'h00, 0, 1'b0);

    // Back-pressure with operand pulses that must be ignored.
    do_op8(8'h57, 8'h83, 32'hC1, 5, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check_eq("no_ghost_op", 32'(out_valid), 0);
    end

    // Reset while the operation is in RUN.
    @(negedge clk);
    a        = 8'h57;
    b        = 8'h83;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pre_rst_busy", 32'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_out_valid", 32'(out_valid), 0);
    check_eq("midrst_in_ready", 32'(in_ready), 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("midrst_discard", 32'(out_valid), 0);
    end
    do_op8(8'h02, 8'h80, 32'h1B, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op8(ra, rb, gf_mul(32'(ra), 32'(rb), 8, 32'h11B), i % 3, 1'(i % 2));
    end

    for (int i = 0; i < 128; i++) begin
      do_op7(7'($urandom), 7'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
